controle_input_conditioner: RTL and testbench

CONTROLE_INPUT_CONDITIONER -- requirements
Module: controle_input_conditioner

---
 rtl/controle_pkg.sv | 32 +++
 rtl/controle_debounce_bit.sv | 62 ++++++
 rtl/controle_input_conditioner.sv | 96 +++++++++
 tb/tb_controle_input_conditioner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// Shared constants for the Controle input conditioner: input counts, default
// debounce timing and the status_word field map.
package controle_pkg;

  localparam int N_SW             = 10;
  localparam int N_KEYS           = 4;
  localparam int DEF_TICK_CYCLES  = 50000;
  localparam int DEF_STABLE_TICKS = 3;

  localparam int STATUS_W = 32;
  localparam int SW_LSB   = 0;
  localparam int SW_W     = N_SW;
  localparam int KEY_LSB  = 10;
  localparam int KEY_W    = N_KEYS;
  localparam int FLAG_LSB = 14;
  localparam int FLAG_W   = N_KEYS;
  localparam int CNT_LSB  = 18;
  localparam int CNT_W    = 8;
  localparam int RSVD_LSB = 26;
  localparam int RSVD_W   = 6;

  // Number of press events in one cycle, widened to the counter width.
  function automatic logic [CNT_W-1:0] count_presses(input logic [N_KEYS-1:0] ev);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, ev[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/controle_debounce_bit.sv
// One conditioned input: 2-flop synchronizer, optional inversion, and a
// tick-sampled agreement counter that commits a level change after STABLE_TICKS.
module controle_debounce_bit #(
  parameter int STABLE_TICKS = 3,
  parameter bit INVERT       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  input  logic tick_i,
  output logic deb_o
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          deb_q;
  logic          deb_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign level   = sync2_q ^ INVERT;
  assign cnt_inc = cnt_q + CW'(1);

  // Any agreeing sample restarts the count, so a chattering input never commits.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (tick_i) begin
      if (level != deb_q) begin
        if (cnt_inc == CW'(STABLE_TICKS)) begin
          deb_d = level;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/controle_input_conditioner.sv
// Conditions the board switches and pushbuttons into the registered status word
// read by the Controle PIO: debounced levels, sticky press flags, press counter.
module controle_input_conditioner
  import controle_pkg::*;
#(
  parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_SW-1:0]     sw,
  input  logic [N_KEYS-1:0]   key_n,
  input  logic                clr_edges,
  output logic [STATUS_W-1:0] status_word
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0]       presc_q;
  logic [PW-1:0]       presc_d;
  logic                tick;
  logic [N_SW-1:0]     sw_deb;
  logic [N_KEYS-1:0]   key_deb;
  logic [N_KEYS-1:0]   key_prev_q;
  logic [N_KEYS-1:0]   press;
  logic [N_KEYS-1:0]   flags_q;
  logic [N_KEYS-1:0]   flags_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [STATUS_W-1:0] status_q;
  logic [STATUS_W-1:0] status_d;

  assign tick    = (presc_q == PW'(TICK_CYCLES - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    controle_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .INVERT      (1'b0)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .raw_i  (sw[i]),
      .tick_i (tick),
      .deb_o  (sw_deb[i])
    );
  end

  // Keys are active-low on the board; inverted after the synchronizer so 1 = pressed.
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    controle_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .INVERT      (1'b1)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .raw_i  (key_n[k]),
      .tick_i (tick),
      .deb_o  (key_deb[k])
    );
  end

  assign press = key_deb & ~key_prev_q;

  // A press in the same cycle as clr_edges keeps its flag.
  assign flags_d = (clr_edges ? '0 : flags_q) | press;
  assign cnt_d   = cnt_q + count_presses(press);

  always_comb begin
    status_d                       = '0;
    status_d[SW_LSB   +: SW_W]     = sw_deb;
    status_d[KEY_LSB  +: KEY_W]    = key_deb;
    status_d[FLAG_LSB +: FLAG_W]   = flags_q;
    status_d[CNT_LSB  +: CNT_W]    = cnt_q;
    status_d[RSVD_LSB +: RSVD_W]   = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      key_prev_q <= '0;
      flags_q    <= '0;
      cnt_q      <= '0;
      status_q   <= '0;
    end else begin
      presc_q    <= presc_d;
      key_prev_q <= key_deb;
      flags_q    <= flags_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
    end
  end

  assign status_word = status_q;

endmodule

// File: tb/tb_controle_input_conditioner.sv
// Directed bench for controle_input_conditioner with TICK_CYCLES=4, STABLE_TICKS=3.
module tb_controle_input_conditioner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  sw;
  logic [3:0]  key_n;
  logic        clr_edges;
  logic [31:0] status_word;

  int checks = 0;
  int errors = 0;
  int lat;

  controle_input_conditioner #(
    .TICK_CYCLES (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw         (sw),
    .key_n      (key_n),
    .clr_edges  (clr_edges),
    .status_word(status_word)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_status_bit(input int b, input int limit, output int cycles);
    cycles = limit + 1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (status_word[b] === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic press_keys(input logic [3:0] mask);
    @(negedge clk);
    key_n = key_n & ~mask;
    repeat (24) @(negedge clk);
  endtask

  task automatic release_keys(input logic [3:0] mask);
    @(negedge clk);
    key_n = key_n | mask;
    repeat (24) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    sw        = '0;
    key_n     = 4'hF;
    clr_edges = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hold", status_word, 32'h0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_reset", status_word, 32'h0);

    // Single switch edge: latency window and no collateral bits.
    sw[0] = 1'b1;
    wait_status_bit(0, 30, lat);
    check("sw0_latency_in_window", 32'((lat >= 12) && (lat <= 16)), 32'h1);
    repeat (4) @(negedge clk);
    check("sw0_only_bit", status_word, 32'h0000_0001);

    // Chatter at the tick rate must never commit.
    for (int t = 0; t < 16; t++) begin
      sw[1] = ~sw[1];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check("sw1_chatter_hold", 32'(status_word[1]), 32'h0);
      end
    end
    sw[1] = 1'b1;
    wait_status_bit(1, 30, lat);
    check("sw1_settle_latency", 32'(lat <= 16), 32'h1);
    repeat (4) @(negedge clk);
    check("sw01_status", status_word, 32'h0000_0003);

    // Key 2: press, release, press, then clear flags.
    press_keys(4'h4);
    check("key2_press1", status_word, 32'h0005_1003);
    release_keys(4'h4);
    check("key2_release1", status_word, 32'h0005_0003);
    press_keys(4'h4);
    check("key2_press2", status_word, 32'h0009_1003);
    release_keys(4'h4);
    check("key2_release2", status_word, 32'h0009_0003);
    @(negedge clk);
    clr_edges = 1'b1;
    @(negedge clk);
    clr_edges = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_keeps_count", status_word, 32'h0008_0003);

    // Build flags=F, count=0x25, then reset asynchronously mid-cycle.
    for (int r = 0; r < 8; r++) begin
      press_keys(4'hF);
      release_keys(4'hF);
    end
    press_keys(4'h7);
    release_keys(4'h7);
    check("pre_reset_state", status_word, 32'h0097_C003);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    sw      = '0;
    #1;
    check("async_reset_clears", status_word, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("post_reset_idle", status_word, 32'h0);
    end

    // Fresh reset with key 0 already down: tick phase is known, so clr_edges
    // lands exactly on the press-event cycle (debounced rises at edge 12).
    @(negedge clk);
    reset_n = 1'b0;
    key_n   = 4'hE;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    clr_edges = 1'b1;
    @(negedge clk);
    clr_edges = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_vs_press_set_wins", status_word, 32'h0004_4400);
    release_keys(4'h1);

    // Two simultaneous presses add two; then wrap the counter.
    press_keys(4'h9);
    check("dual_press_count", status_word, 32'h000E_6400);
    release_keys(4'h9);
    for (int r = 0; r < 63; r++) begin
      press_keys(4'hF);
      release_keys(4'hF);
    end
    check("count_ff", status_word, 32'h03FF_C000);
    press_keys(4'h2);
    release_keys(4'h2);
    check("count_wrap_zero", status_word, 32'h0003_C000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
